busy_table_mp: RTL and testbench
================================

BUSY_TABLE_MP -- requirements
Module: busy_table_mp

Interface
REQ-001 SHALL have parameter PRF_NUM, default 64, meaning number of physical registers; PRF index width = $clog2(PRF_NUM).
REQ-002 SHALL have parameter N_RD, default 4, meaning number of busy read ports.
REQ-003 SHALL have parameter N_SET, default 2, meaning number of set-busy ports (rename allocations per cycle).
REQ-004 SHALL have parameter N_CLR, default 4, meaning number of immediate clear ports (writeback).
REQ-005 SHALL have parameter DQ_DEPTH, default 4, meaning number of delayed-clear slots.
REQ-006 SHALL have parameter MAX_DLY, default 15, meaning largest legal delay; DW = $clog2(MAX_DLY+1).
REQ-007 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-008 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have ports: flush  in  1  synchronous pipeline flush.
REQ-010 SHALL have ports: rd_num  in  N_RD x PRF index width  and  busy  out  N_RD  busy status per read port.
REQ-011 SHALL have ports: set_busy  in  N_SET  and  set_busy_num  in  N_SET x PRF index width.
REQ-012 SHALL have ports: clr_busy  in  N_CLR  and  clr_busy_num  in  N_CLR x PRF index width.
REQ-013 SHALL have ports: dclr_valid  in  1;  dclr_num  in  PRF index width;  dclr_delay  in  DW;  dclr_ready  out  1  free slot available.
REQ-014 SHALL have ports: wake_valid  out  1  and  wake_num  out  PRF index width  delayed-clear fire indication.
REQ-015 SHALL have ports: busy_cnt  out  $clog2(PRF_NUM+1)  registered count of busy entries.

Function
REQ-016 SHALL hold one busy bit per PRF; PRF 0 SHALL always read not busy and set requests to PRF 0 SHALL be ignored.
REQ-017 SHALL compute busy combinationally: stored bit AND NOT (any immediate clear or delayed-clear fire matching rd_num this cycle).
REQ-018 SHALL make sets visible to reads from the next cycle only (no set bypass).
REQ-019 SHALL apply set over clear when the same PRF is both set and cleared in one cycle.
REQ-020 SHALL accept a delayed clear when dclr_valid and dclr_ready are both high; dclr_valid while dclr_ready is low SHALL be dropped.
REQ-021 SHALL treat dclr_delay = 0 as an immediate clear in the accept cycle, consuming no slot.
REQ-022 SHALL, for accepted delay d >= 1 in cycle t, fire in cycle t+d: wake_valid=1, wake_num=dclr_num, bypass per REQ-017, bit cleared at end of cycle t+d.
REQ-023 SHALL allocate the lowest-index free slot; each occupied slot SHALL decrement its counter every cycle and free itself in its fire cycle.
REQ-024 SHALL resolve two slots firing in the same cycle by firing the lower slot and holding the higher slot's counter at 1 until the next cycle.
REQ-025 SHALL drive dclr_ready = 1 iff at least one slot is free at start of cycle (slot freed this cycle not reusable until next cycle).
REQ-026 SHALL, on flush, clear all busy bits, empty all slots, force wake_valid=0, and ignore all set/clear/dclr inputs of that cycle.
REQ-027 SHALL update busy_cnt each cycle to the popcount of the busy array after that cycle's updates.
REQ-028 SHALL treat duplicate set or clear numbers across ports in one cycle as a single operation.

Reset
REQ-029 SHALL, while rst is low, asynchronously clear all busy bits, empty all slots, and drive busy=0, dclr_ready=1, wake_valid=0, wake_num=0, busy_cnt=0.
REQ-030 SHALL, on reset asserted mid-countdown, discard pending slots with no wake emitted after reset release.

Structure
REQ-031 SHALL take PRFNum and the default PRF_NUM constant from the shared defines package; the slot record (valid, num, counter) SHALL be a typedef in that package.
REQ-032 SHALL place the slot array in one sub-module, dclr_slots, exporting fire valid/num and ready.

Verification
REQ-033 Set PRF 5, read PRF 5 same cycle -> busy=0; next cycle -> busy=1, busy_cnt=1.
REQ-034 Busy PRF 7, clr_busy_num[2]=7 and read 7 same cycle -> busy=0 that cycle; stays 0 afterwards.
REQ-035 Busy PRF 9, dclr 9 delay 3 at cycle 10 -> busy=1 cycles 11-12, wake_valid with wake_num=9 and busy=0 in cycle 13.
REQ-036 Fill 4 slots with delay 15 -> dclr_ready=0; fifth request dropped; ready returns 1 the cycle after first fire.
REQ-037 Busy PRFs 3,4 with pending dclr, flush with set PRF 6 same cycle -> busy_cnt=0, no wake, PRF 6 not busy.
REQ-038 Set and clear PRF 12 same cycle -> busy=1 next cycle; set PRF 0 -> busy remains 0.

Source files
------------

// File: rtl/busy_table_mp_pkg.sv
// Shared defines for the busy table slice.
// Holds the physical register file size, the default delay range and the
// delayed-clear slot record used by the slot array.
package busy_table_mp_pkg;

  localparam int PRFNum          = 64;
  localparam int PRF_NUM_DEFAULT = PRFNum;
  localparam int MAX_DLY_DEFAULT = 15;

  // Slot fields are sized for the shared PRF / delay configuration.
  localparam int SLOT_NUM_W = $clog2(PRFNum);
  localparam int SLOT_CNT_W = $clog2(MAX_DLY_DEFAULT + 1);

  typedef struct packed {
    logic                  valid;
    logic [SLOT_NUM_W-1:0] num;
    logic [SLOT_CNT_W-1:0] cnt;
  } dclr_slot_t;

endpackage

// File: rtl/busy_table_mp_if.sv
// Delayed-clear request / wake-up bundle of the busy table.
// Ports (signals):
//   dclr_valid, dclr_num, dclr_delay : delayed-clear request (master -> table)
//   dclr_ready                       : a free slot exists (table -> master)
//   wake_valid, wake_num             : delayed clear firing this cycle
interface busy_table_mp_if #(
  parameter int PW = $clog2(busy_table_mp_pkg::PRFNum),
  parameter int DW = $clog2(busy_table_mp_pkg::MAX_DLY_DEFAULT + 1)
) ();

  logic          dclr_valid;
  logic [PW-1:0] dclr_num;
  logic [DW-1:0] dclr_delay;
  logic          dclr_ready;
  logic          wake_valid;
  logic [PW-1:0] wake_num;

  modport master (
    output dclr_valid, dclr_num, dclr_delay,
    input  dclr_ready, wake_valid, wake_num
  );

  modport slave (
    input  dclr_valid, dclr_num, dclr_delay,
    output dclr_ready, wake_valid, wake_num
  );

endinterface

// File: rtl/busy_table_mp_dclr_slots.sv
// Delayed-clear slot array.
// Each slot holds a PRF number and a countdown; a slot fires when its
// counter reaches 1 and frees itself in that cycle.
// Ports:
//   clk, rst (async, active-low), flush
//   req_valid/req_num/req_delay : request; taken when a slot is free and delay != 0
//   ready                       : at least one slot free at start of cycle
//   fire_valid/fire_num         : slot firing this cycle (lowest index wins)
module dclr_slots
  import busy_table_mp_pkg::*;
#(
  parameter int DQ_DEPTH = 4,
  parameter int PW       = 6,
  parameter int DW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          req_valid,
  input  logic [PW-1:0] req_num,
  input  logic [DW-1:0] req_delay,
  output logic          ready,
  output logic          fire_valid,
  output logic [PW-1:0] fire_num
);

  localparam logic [SLOT_CNT_W-1:0] CNT_ONE = SLOT_CNT_W'(1);

  dclr_slot_t    slots_q [DQ_DEPTH];
  logic          have_free;
  int            free_idx;
  logic          have_fire;
  int            fire_idx;
  logic [PW-1:0] fire_num_raw;
  logic          accept;

  // Downward scans so the lowest matching index is the one left standing.
  always_comb begin
    have_free    = 1'b0;
    free_idx     = 0;
    have_fire    = 1'b0;
    fire_idx     = 0;
    fire_num_raw = '0;
    for (int i = DQ_DEPTH - 1; i >= 0; i--) begin
      if (!slots_q[i].valid) begin
        have_free = 1'b1;
        free_idx  = i;
      end
      if (slots_q[i].valid && slots_q[i].cnt == CNT_ONE) begin
        have_fire    = 1'b1;
        fire_idx     = i;
        fire_num_raw = PW'(slots_q[i].num);
      end
    end
  end

  // Ready comes from registered state only, so a slot freed by this
  // cycle's fire is not offered until the next cycle.
  assign ready      = have_free;
  assign accept     = req_valid && have_free && !flush && (req_delay != '0);
  assign fire_valid = have_fire && !flush;
  assign fire_num   = fire_valid ? fire_num_raw : '0;

  // Slots that lose fire arbitration keep their counter at 1 and retry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DQ_DEPTH; i++) slots_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DQ_DEPTH; i++) slots_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DQ_DEPTH; i++) begin
        if (accept && i == free_idx) begin
          slots_q[i].valid <= 1'b1;
          slots_q[i].num   <= SLOT_NUM_W'(req_num);
          slots_q[i].cnt   <= SLOT_CNT_W'(req_delay);
        end else if (slots_q[i].valid) begin
          if (slots_q[i].cnt != CNT_ONE) begin
            slots_q[i].cnt <= slots_q[i].cnt - CNT_ONE;
          end else if (have_fire && i == fire_idx) begin
            slots_q[i].valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/busy_table_mp.sv
// Multi-port PRF busy table with immediate and delayed clears.
// Ports:
//   clk, rst (async, active-low), flush (sync)
//   rd_num[N_RD] -> busy[N_RD]   : busy status with same-cycle clear bypass
//   set_busy/set_busy_num        : mark busy, visible next cycle
//   clr_busy/clr_busy_num        : immediate clear (writeback)
//   dq (busy_table_mp_if.slave)  : delayed-clear request and wake output
//   busy_cnt                     : registered popcount of the busy array
module busy_table_mp
  import busy_table_mp_pkg::*;
#(
  parameter int PRF_NUM  = PRF_NUM_DEFAULT,
  parameter int N_RD     = 4,
  parameter int N_SET    = 2,
  parameter int N_CLR    = 4,
  parameter int DQ_DEPTH = 4,
  parameter int MAX_DLY  = MAX_DLY_DEFAULT,
  localparam int PW      = $clog2(PRF_NUM),
  localparam int DW      = $clog2(MAX_DLY + 1),
  localparam int CW      = $clog2(PRF_NUM + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [PW-1:0]    rd_num       [N_RD],
  output logic [N_RD-1:0]  busy,
  input  logic [N_SET-1:0] set_busy,
  input  logic [PW-1:0]    set_busy_num [N_SET],
  input  logic [N_CLR-1:0] clr_busy,
  input  logic [PW-1:0]    clr_busy_num [N_CLR],
  busy_table_mp_if.slave   dq,
  output logic [CW-1:0]    busy_cnt
);

  logic [PRF_NUM-1:0] busy_q;
  logic [PRF_NUM-1:0] busy_next;
  logic [PRF_NUM-1:0] clr_vec;
  logic [PRF_NUM-1:0] set_vec;
  logic [CW-1:0]      cnt_next;
  logic               slot_ready;
  logic               fire_valid;
  logic [PW-1:0]      fire_num;
  logic               imm_dclr;

  dclr_slots #(
    .DQ_DEPTH (DQ_DEPTH),
    .PW       (PW),
    .DW       (DW)
  ) u_slots (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (dq.dclr_valid),
    .req_num    (dq.dclr_num),
    .req_delay  (dq.dclr_delay),
    .ready      (slot_ready),
    .fire_valid (fire_valid),
    .fire_num   (fire_num)
  );

  assign dq.dclr_ready = slot_ready;
  assign dq.wake_valid = fire_valid;
  assign dq.wake_num   = fire_num;

  // A zero-delay request behaves as an immediate clear and takes no slot.
  assign imm_dclr = dq.dclr_valid && slot_ready && !flush && (dq.dclr_delay == '0);

  // Decoding into bit vectors merges duplicate numbers across ports.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (!flush) begin
      for (int k = 0; k < N_CLR; k++) begin
        if (clr_busy[k]) clr_vec[clr_busy_num[k]] = 1'b1;
      end
      if (imm_dclr)   clr_vec[dq.dclr_num] = 1'b1;
      if (fire_valid) clr_vec[fire_num]    = 1'b1;
      for (int k = 0; k < N_SET; k++) begin
        if (set_busy[k]) set_vec[set_busy_num[k]] = 1'b1;
      end
    end
    set_vec[0] = 1'b0;
  end

  // Set wins over clear; PRF 0 is never stored as busy.
  always_comb begin
    busy_next = flush ? '0 : ((busy_q & ~clr_vec) | set_vec);
    cnt_next  = '0;
    for (int i = 0; i < PRF_NUM; i++) cnt_next = cnt_next + CW'(busy_next[i]);
  end

  // Reads see this cycle's clears but not this cycle's sets.
  always_comb begin
    busy = '0;
    for (int i = 0; i < N_RD; i++) busy[i] = busy_q[rd_num[i]] & ~clr_vec[rd_num[i]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      busy_q   <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_busy_table_mp.sv
module tb_busy_table_mp;

  localparam int NRD  = 4;
  localparam int NSET = 2;
  localparam int NCLR = 4;
  localparam int PW   = 6;
  localparam int DW   = 4;
  localparam int CW   = 7;

  localparam int K_WV  = 4;
  localparam int K_WN  = 5;
  localparam int K_RDY = 6;
  localparam int K_CNT = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush;
  logic [PW-1:0]   rd_num       [NRD];
  logic [NRD-1:0]  busy;
  logic [NSET-1:0] set_busy;
  logic [PW-1:0]   set_busy_num [NSET];
  logic [NCLR-1:0] clr_busy;
  logic [PW-1:0]   clr_busy_num [NCLR];
  logic [CW-1:0]   busy_cnt;

  busy_table_mp_if #(.PW(PW), .DW(DW)) dq ();

  busy_table_mp #(
    .PRF_NUM(64), .N_RD(NRD), .N_SET(NSET), .N_CLR(NCLR), .DQ_DEPTH(4), .MAX_DLY(15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .rd_num       (rd_num),
    .busy         (busy),
    .set_busy     (set_busy),
    .set_busy_num (set_busy_num),
    .clr_busy     (clr_busy),
    .clr_busy_num (clr_busy_num),
    .dq           (dq.slave),
    .busy_cnt     (busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    kind;
    int    val;
  } exp_t;

  exp_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int observe(input int kind);
    case (kind)
      K_WV:    return int'(dq.wake_valid);
      K_WN:    return int'(dq.wake_num);
      K_RDY:   return int'(dq.dclr_ready);
      K_CNT:   return int'(busy_cnt);
      default: return int'(busy[kind[1:0]]);
    endcase
  endfunction

  task automatic push_exp(input string tag, input int kind, input int val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic idle();
    flush          = 1'b0;
    set_busy       = '0;
    clr_busy       = '0;
    dq.dclr_valid  = 1'b0;
    dq.dclr_num    = '0;
    dq.dclr_delay  = '0;
    for (int i = 0; i < NRD; i++)  rd_num[i]       = '0;
    for (int i = 0; i < NSET; i++) set_busy_num[i] = '0;
    for (int i = 0; i < NCLR; i++) clr_busy_num[i] = '0;
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.kind), e.val);
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_set(input int p, input int n);
    set_busy[p] = 1'b1; set_busy_num[p] = PW'(n);
  endtask
  task automatic do_clr(input int p, input int n);
    clr_busy[p] = 1'b1; clr_busy_num[p] = PW'(n);
  endtask
  task automatic do_dclr(input int n, input int d);
    dq.dclr_valid = 1'b1; dq.dclr_num = PW'(n); dq.dclr_delay = DW'(d);
  endtask
  task automatic rd(input int p, input int n);
    rd_num[p] = PW'(n);
  endtask

  initial begin
    idle();
    // reset state
    rd(0, 5);
    push_exp("rst_busy", 0, 0); push_exp("rst_ready", K_RDY, 1);
    push_exp("rst_wv", K_WV, 0); push_exp("rst_wn", K_WN, 0); push_exp("rst_cnt", K_CNT, 0);
    step();
    rst = 1'b1;
    step();

    // set visible next cycle only
    do_set(0, 5); rd(0, 5);
    push_exp("set5_same", 0, 0); push_exp("set5_same_cnt", K_CNT, 0);
    step();
    rd(0, 5); push_exp("set5_next", 0, 1); push_exp("set5_cnt", K_CNT, 1);
    step();

    // immediate clear with bypass
    do_set(1, 7); step();
    do_clr(2, 7); rd(1, 7);
    push_exp("clr7_bypass", 1, 0); push_exp("clr7_cnt_pre", K_CNT, 2);
    step();
    rd(1, 7); push_exp("clr7_after", 1, 0); push_exp("clr7_cnt", K_CNT, 1);
    step();

    // delayed clear, delay 3
    do_set(0, 9); step();
    do_dclr(9, 3); rd(0, 9);
    push_exp("d9_t0_busy", 0, 1); push_exp("d9_t0_rdy", K_RDY, 1); push_exp("d9_t0_cnt", K_CNT, 2);
    step();
    rd(0, 9); push_exp("d9_t1_busy", 0, 1); push_exp("d9_t1_wv", K_WV, 0); step();
    rd(0, 9); push_exp("d9_t2_busy", 0, 1); push_exp("d9_t2_wv", K_WV, 0); step();
    rd(0, 9);
    push_exp("d9_t3_busy", 0, 0); push_exp("d9_t3_wv", K_WV, 1);
    push_exp("d9_t3_wn", K_WN, 9); push_exp("d9_t3_cnt", K_CNT, 2);
    step();
    rd(0, 9);
    push_exp("d9_t4_busy", 0, 0); push_exp("d9_t4_wv", K_WV, 0); push_exp("d9_t4_cnt", K_CNT, 1);
    step();

    // set over clear, set to PRF 0 ignored
    do_set(0, 12); do_clr(0, 12); do_set(1, 0); rd(0, 12);
    push_exp("sc12_same", 0, 0);
    step();
    rd(0, 12); rd(1, 0);
    push_exp("sc12_next", 0, 1); push_exp("prf0_busy", 1, 0); push_exp("sc12_cnt", K_CNT, 2);
    step();

    // duplicate numbers across ports
    do_set(0, 20); do_set(1, 20); step();
    do_clr(0, 20); do_clr(3, 20); rd(2, 20);
    push_exp("dup_set_cnt", K_CNT, 3); push_exp("dup_clr_bypass", 2, 0);
    step();
    rd(2, 20); push_exp("dup_clr_busy", 2, 0); push_exp("dup_clr_cnt", K_CNT, 2);
    step();

    // delay 0 acts as immediate clear
    do_set(0, 50); step();
    do_dclr(50, 0); rd(0, 50);
    push_exp("d0_bypass", 0, 0); push_exp("d0_rdy", K_RDY, 1); push_exp("d0_cnt_pre", K_CNT, 3);
    step();
    rd(0, 50);
    push_exp("d0_after", 0, 0); push_exp("d0_cnt", K_CNT, 2); push_exp("d0_wv", K_WV, 0);
    step();

    // fill all slots with delay 15; fifth request dropped
    for (int k = 0; k <= 20; k++) begin
      if (k < 5) do_dclr(((k % 2) == 0) ? 5 : 12, 15);
      push_exp($sformatf("full_rdy_k%0d", k), K_RDY, (k < 4) ? 1 : ((k <= 15) ? 0 : 1));
      push_exp($sformatf("full_wv_k%0d", k), K_WV, (k >= 15 && k <= 18) ? 1 : 0);
      if (k >= 15 && k <= 18)
        push_exp($sformatf("full_wn_k%0d", k), K_WN, ((k % 2) == 1) ? 5 : 12);
      push_exp($sformatf("full_cnt_k%0d", k), K_CNT, (k <= 15) ? 2 : ((k == 16) ? 1 : 0));
      step();
    end

    // two slots reaching fire in the same cycle
    do_set(0, 30); do_set(1, 31); step();
    do_dclr(30, 3); step();
    do_dclr(31, 2); step();
    push_exp("cont_b2_wv", K_WV, 0); step();
    rd(0, 31); rd(1, 30);
    push_exp("cont_b3_wv", K_WV, 1); push_exp("cont_b3_wn", K_WN, 30);
    push_exp("cont_b3_b31", 0, 1); push_exp("cont_b3_b30", 1, 0);
    step();
    rd(0, 31);
    push_exp("cont_b4_wv", K_WV, 1); push_exp("cont_b4_wn", K_WN, 31);
    push_exp("cont_b4_b31", 0, 0); push_exp("cont_b4_cnt", K_CNT, 1);
    step();
    push_exp("cont_b5_wv", K_WV, 0); push_exp("cont_b5_cnt", K_CNT, 0);
    step();

    // flush with pending delayed clears and a same-cycle set
    do_set(0, 3); do_set(1, 4); step();
    do_dclr(3, 2); step();
    do_dclr(4, 4); push_exp("fl_cnt_pre", K_CNT, 2); step();
    flush = 1'b1; do_set(0, 6);
    push_exp("fl_wv", K_WV, 0); push_exp("fl_wn", K_WN, 0); push_exp("fl_cnt_same", K_CNT, 2);
    step();
    rd(0, 6); rd(1, 3); rd(2, 4);
    push_exp("fl_b6", 0, 0); push_exp("fl_b3", 1, 0); push_exp("fl_b4", 2, 0);
    push_exp("fl_cnt", K_CNT, 0); push_exp("fl_rdy", K_RDY, 1); push_exp("fl_wv1", K_WV, 0);
    step();
    for (int k = 2; k <= 4; k++) begin
      push_exp($sformatf("fl_wv%0d", k), K_WV, 0);
      step();
    end

    // reset asserted mid-countdown
    do_set(0, 40); step();
    do_dclr(40, 5); step();
    step();
    rst = 1'b0; rd(0, 40);
    push_exp("rm_busy", 0, 0); push_exp("rm_rdy", K_RDY, 1); push_exp("rm_wv", K_WV, 0);
    push_exp("rm_wn", K_WN, 0); push_exp("rm_cnt", K_CNT, 0);
    step();
    rst = 1'b1;
    for (int k = 0; k < 7; k++) begin
      push_exp($sformatf("rm_post_wv%0d", k), K_WV, 0);
      push_exp($sformatf("rm_post_cnt%0d", k), K_CNT, 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
